// File: rtl/nibble_serial_addsub.sv
// Multi-nibble adder/subtractor: iterates a 4-bit add/sub slice LS nibble first,
// chaining carry through a register, with valid/ready on both sides.
module nibble_serial_addsub #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   s,
   output logic                   cout,
   output logic                   ovf
);

   localparam int unsigned W     = 4 * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned SH_W  = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             sub_q, sub_d;
   logic [W-1:0]     s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;

   logic [SH_W-1:0]  sh;
   logic [W-1:0]     a_sh, b_sh;
   logic [3:0]       a_nib, bx_nib;
   logic [4:0]       sum5;

   // Current nibble slice: operands selected by index, b conditionally inverted
   always_comb begin
      sh     = {idx_q, 2'b00};
      a_sh   = a_q >> sh;
      b_sh   = b_q >> sh;
      a_nib  = a_sh[3:0];
      bx_nib = b_sh[3:0] ^ {4{sub_q}};
      sum5   = {1'b0, a_nib} + {1'b0, bx_nib} + {4'b0000, carry_q};
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sub_d       = sub_q;
      s_d         = s_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               carry_d = sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            s_d     = (s_q & ~(W'(4'hF) << sh)) | (W'(sum5[3:0]) << sh);
            carry_d = sum5[4];
            if (idx_q == LAST_IDX) begin
               cout_d      = sum5[4];
               // Signed overflow: operands share a sign that the result does not
               ovf_d       = (a_nib[3] == bx_nib[3]) && (sum5[3] != a_nib[3]);
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = IDX_W'(idx_q + 1'b1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
